// File: rtl/amiga_line_capture.sv
// Captures visible Amiga scan lines into a ping-pong line cache and hands each
// completed line to the SDRAM controller over a toggle request/acknowledge pair.
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_HSYNC | idle between lines, waiting for an hsync falling edge
// SKIP       | counting off the left border strobes of a visible line
// CAPTURE    | writing one pixel per strobe into the current cache row
// HANDOFF    | one cycle: request the SDRAM write or count an overrun
module amiga_line_capture #(
    parameter logic [9:0] H_START     = 10'd64,
    parameter logic [9:0] LINE_PIXELS = 10'd752,
    parameter logic [8:0] V_START     = 9'd26,
    parameter logic [8:0] V_LINES     = 9'd288
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        px_en,
    input  logic [11:0] px_rgb,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic        laced,
    input  logic        field,
    output logic [10:0] sc_wr_address,
    output logic        sc_wr_en,
    output logic [15:0] sc_wr_data,
    output logic        s_req,
    input  logic        s_ack,
    output logic        s_cache_row,
    output logic [9:0]  s_sdram_row,
    output logic [7:0]  overrun_count
);

    typedef enum logic [1:0] {WAIT_HSYNC, SKIP, CAPTURE, HANDOFF} state_t;

    state_t      state, state_next;
    logic        hs_q, vs_q;
    logic        hs_fall, vs_fall;
    logic [8:0]  line_cnt;
    logic [8:0]  cap_line;
    logic [8:0]  vline;
    logic        field_q;
    logic [9:0]  col;
    logic [9:0]  skip;
    logic [9:0]  v_end;
    logic        wr_row;
    logic        in_range;
    logic        start_line, skip_inc, do_write, do_handoff;

    assign hs_fall  = hs_q & ~hsync_n;
    assign vs_fall  = vs_q & ~vsync_n;
    assign v_end    = {1'b0, V_START} + {1'b0, V_LINES};
    assign in_range = (line_cnt >= V_START) && ({1'b0, line_cnt} < v_end);
    assign vline    = cap_line - V_START;

    always_comb begin
        state_next = state;
        start_line = 1'b0;
        skip_inc   = 1'b0;
        do_write   = 1'b0;
        do_handoff = 1'b0;
        if (vs_fall) begin
            state_next = WAIT_HSYNC;
        end else begin
            case (state)
                WAIT_HSYNC: begin
                    if (hs_fall) begin
                        start_line = 1'b1;
                        if (in_range) state_next = SKIP;
                    end
                end
                SKIP, CAPTURE: begin
                    // a new hsync mid-line drops the partial line and re-arms for the next
                    if (hs_fall) begin
                        start_line = 1'b1;
                        state_next = in_range ? SKIP : WAIT_HSYNC;
                    end else if (px_en) begin
                        if (state == SKIP) begin
                            skip_inc = 1'b1;
                            if (skip == H_START - 10'd1) state_next = CAPTURE;
                        end else begin
                            do_write = 1'b1;
                            if (col == LINE_PIXELS - 10'd1) state_next = HANDOFF;
                        end
                    end
                end
                HANDOFF: begin
                    do_handoff = 1'b1;
                    state_next = WAIT_HSYNC;
                end
                default: state_next = WAIT_HSYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_HSYNC;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            line_cnt      <= 9'd0;
            cap_line      <= 9'd0;
            field_q       <= 1'b0;
            col           <= 10'd0;
            skip          <= 10'd0;
            wr_row        <= 1'b0;
            sc_wr_en      <= 1'b0;
            sc_wr_address <= 11'd0;
            sc_wr_data    <= 16'd0;
            s_req         <= 1'b0;
            s_cache_row   <= 1'b0;
            s_sdram_row   <= 10'd0;
            overrun_count <= 8'd0;
        end else begin
            hs_q     <= hsync_n;
            vs_q     <= vsync_n;
            sc_wr_en <= do_write;
            if (do_write) begin
                sc_wr_address <= {wr_row, col};
                sc_wr_data    <= {4'd0, px_rgb};
                col           <= col + 10'd1;
            end
            if (start_line) begin
                col      <= 10'd0;
                skip     <= 10'd0;
                cap_line <= line_cnt;
            end else if (skip_inc) begin
                skip <= skip + 10'd1;
            end
            if (vs_fall) begin
                line_cnt <= 9'd0;
                field_q  <= field;
            end else if (hs_fall && line_cnt != 9'd511) begin
                line_cnt <= line_cnt + 9'd1;
            end
            // a still-pending request keeps wr_row, so the next line overwrites this one
            if (do_handoff) begin
                if (s_req == s_ack) begin
                    s_req       <= ~s_req;
                    s_cache_row <= wr_row;
                    s_sdram_row <= laced ? {vline, field_q} : {1'b0, vline};
                    wr_row      <= ~wr_row;
                end else if (overrun_count != 8'hFF) begin
                    overrun_count <= overrun_count + 8'd1;
                end
            end
        end
    end

endmodule
